// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and types for the packet-level UART transmit arbiter.
package uart_tx_arbiter_pkg;

   localparam int          IDX_W      = 4;
   localparam logic [3:0]  HDR_NIBBLE = 4'hA;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   // Channel-ID header byte announcing which requester owns the packet.
   function automatic logic [7:0] hdr_byte(input logic [IDX_W-1:0] id);
      return {HDR_NIBBLE, id};
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the uart_tx din/din_valid/din_ready handshake.
interface uart_tx_arbiter_if #(
   parameter int N_REQ = 4
) ();

   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   req_valid;
   logic [N_REQ-1:0]   req_last;
   logic [N_REQ-1:0]   req_ready;
   logic [7:0]         tx_data;
   logic               tx_valid;
   logic               tx_ready;

   modport master (
      output req_data, req_valid, req_last, tx_ready,
      input  req_ready, tx_data, tx_valid
   );

   modport slave (
      input  req_data, req_valid, req_last, tx_ready,
      output req_ready, tx_data, tx_valid
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after last_grant+1, with wrap.
module rr_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     i_req,
   input  logic [IDX_W-1:0] i_last_grant,
   output logic [N-1:0]     o_grant,
   output logic [IDX_W-1:0] o_idx
);

   logic [2*N-1:0] w_dbl;
   logic [N-1:0]   w_rot;
   logic           w_found;
   int             w_sel;

   // Rotating a doubled copy puts the highest-priority requester at bit 0.
   always_comb begin
      w_dbl   = {i_req, i_req};
      w_rot   = N'(w_dbl >> (int'(i_last_grant) + 1));
      w_found = 1'b0;
      w_sel   = 0;
      o_grant = '0;
      o_idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (!w_found && w_rot[i]) begin
            w_found = 1'b1;
            w_sel   = (int'(i_last_grant) + 1 + i) % N;
            o_idx   = IDX_W'(w_sel);
            o_grant = {{(N-1){1'b0}}, 1'b1} << w_sel;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte transmitter between N_REQ packet requesters,
// with optional channel header, one-entry output register and gap timeout.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int HEADER_EN   = 1,
   parameter int GAP_TIMEOUT = 1024
) (
   input  logic              clock,
   input  logic              reset,
   uart_tx_arbiter_if.slave  bus,
   output logic [IDX_W-1:0]  grant_id,
   output logic              busy,
   output logic              abort
);

   localparam int GAP_W = (GAP_TIMEOUT > 1) ? $clog2(GAP_TIMEOUT + 1) : 1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [7:0]        r_ob_data;
   logic              r_ob_valid;
   logic [7:0]        w_ob_data_nxt;
   logic              w_load;
   logic [IDX_W-1:0]  r_grant_id;
   logic [IDX_W-1:0]  w_grant_nxt;
   logic [IDX_W-1:0]  r_last_grant;
   logic [IDX_W-1:0]  w_last_nxt;
   logic [GAP_W-1:0]  r_gap_cnt;
   logic [GAP_W-1:0]  w_gap_nxt;
   logic              r_abort;
   logic              w_abort_nxt;

   logic [N_REQ-1:0]  w_req_ready;
   logic [N_REQ-1:0]  w_arb_grant;
   logic [IDX_W-1:0]  w_arb_idx;
   logic              w_any;
   logic              w_ob_free;
   logic              w_gnt_valid;
   logic              w_gnt_last;
   logic [7:0]        w_gnt_data;

   rr_arbiter #(
      .N (N_REQ)
   ) u_rr (
      .i_req        (bus.req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_arb_grant),
      .o_idx        (w_arb_idx)
   );

   assign w_any     = |w_arb_grant;
   assign w_ob_free = !r_ob_valid || bus.tx_ready;

   // Mux out the granted requester's stream.
   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_last  = 1'b0;
      w_gnt_data  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (r_grant_id == IDX_W'(i)) begin
            w_gnt_valid = bus.req_valid[i];
            w_gnt_last  = bus.req_last[i];
            w_gnt_data  = bus.req_data[8*i +: 8];
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_grant_nxt   = r_grant_id;
      w_last_nxt    = r_last_grant;
      w_gap_nxt     = r_gap_cnt;
      w_abort_nxt   = 1'b0;
      w_load        = 1'b0;
      w_ob_data_nxt = r_ob_data;
      w_req_ready   = '0;
      case (r_state)
         ST_IDLE: begin
            w_gap_nxt = '0;
            if (w_any) begin
               w_grant_nxt = w_arb_idx;
               w_state_nxt = (HEADER_EN != 0) ? ST_HDR : ST_DATA;
            end
         end
         ST_HDR: begin
            w_gap_nxt = '0;
            if (w_ob_free) begin
               w_load        = 1'b1;
               w_ob_data_nxt = hdr_byte(r_grant_id);
               w_state_nxt   = ST_DATA;
            end
         end
         ST_DATA: begin
            for (int i = 0; i < N_REQ; i++) begin
               w_req_ready[i] = w_ob_free && (r_grant_id == IDX_W'(i));
            end
            // A handshake wins over a timeout landing in the same cycle.
            if (w_gnt_valid && w_ob_free) begin
               w_load        = 1'b1;
               w_ob_data_nxt = w_gnt_data;
               w_gap_nxt     = '0;
               if (w_gnt_last) begin
                  w_last_nxt  = r_grant_id;
                  w_state_nxt = ST_IDLE;
               end
            end else if (!w_gnt_valid && (GAP_TIMEOUT != 0)) begin
               if (r_gap_cnt == GAP_W'(GAP_TIMEOUT - 1)) begin
                  w_abort_nxt = 1'b1;
                  w_last_nxt  = r_grant_id;
                  w_gap_nxt   = '0;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_gap_nxt = r_gap_cnt + 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_grant_id   <= '0;
         r_last_grant <= IDX_W'(N_REQ - 1);
         r_gap_cnt    <= '0;
         r_abort      <= 1'b0;
         r_ob_valid   <= 1'b0;
         r_ob_data    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_grant_id   <= w_grant_nxt;
         r_last_grant <= w_last_nxt;
         r_gap_cnt    <= w_gap_nxt;
         r_abort      <= w_abort_nxt;
         // Loads only happen while free, so a drain and a refill can share a cycle.
         if (w_load) begin
            r_ob_valid <= 1'b1;
            r_ob_data  <= w_ob_data_nxt;
         end else if (w_ob_free) begin
            r_ob_valid <= 1'b0;
         end
      end
   end

   assign bus.tx_data   = r_ob_data;
   assign bus.tx_valid  = r_ob_valid;
   assign bus.req_ready = w_req_ready;
   assign grant_id      = r_grant_id;
   assign busy          = (r_state != ST_IDLE);
   assign abort         = r_abort;

endmodule
